// File: rtl/seg_scan_decoder.sv
// Rebuilds the 4-digit hex value shown by a multiplexed seven-segment scan.
// Define SEG_ERR_CNT_EN to enable the saturating undecodable-capture counter on err_cnt.
module seg_scan_decoder #(
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  en_n,
  input  logic [6:0]  segs,
  output logic [15:0] value,
  output logic [3:0]  blank,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        onehot_err,
  output logic        stale,
  output logic [7:0]  err_cnt
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYC);
  localparam logic [SW-1:0] SETTLE_M1  = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_M1     = TW'(TIMEOUT_CYC - 1);

  // Returns {err, blank, nibble}.
  function automatic logic [5:0] seg_decode(input logic [6:0] s);
    logic [5:0] r;
    r = 6'b10_0000;
    case (s)
      7'h7E: r = 6'h00;
      7'h30: r = 6'h01;
      7'h6D: r = 6'h02;
      7'h79: r = 6'h03;
      7'h33: r = 6'h04;
      7'h5B: r = 6'h05;
      7'h5F: r = 6'h06;
      7'h70: r = 6'h07;
      7'h7F: r = 6'h08;
      7'h7B: r = 6'h09;
      7'h77: r = 6'h0A;
      7'h1F: r = 6'h0B;
      7'h4E: r = 6'h0C;
      7'h3D: r = 6'h0D;
      7'h4F: r = 6'h0E;
      7'h47: r = 6'h0F;
      7'h00: r = 6'b01_0000;
      default: r = 6'b10_0000;
    endcase
    return r;
  endfunction

  logic [3:0]    en_s1_q, en_s2_q;
  logic [6:0]    seg_s1_q, seg_s2_q;
  logic [10:0]   pat_prev_q;
  logic [SW-1:0] stab_q, stab_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0]    mask_q, mask_d;
  logic          stale_q, stale_d;
  logic [15:0]   value_q;
  logic [3:0]    blank_q, derr_q;
  logic          fv_q, ferr_q, oh_err_q;
  logic [3:0]    nib_q [4];
  logic [3:0]    blk_st_q, derr_st_q;

  logic          chg, settle_hit, sel_ok, cap_dig, cap_bad, frame_go, to_hit;
  logic [1:0]    sel_idx;
  logic [5:0]    dec;

  assign chg        = {en_s2_q, seg_s2_q} != pat_prev_q;
  assign settle_hit = !chg && (stab_q == SETTLE_M1);
  assign dec        = seg_decode(seg_s2_q);

  always_comb begin
    sel_ok  = 1'b1;
    sel_idx = 2'd0;
    case (en_s2_q)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_ok  = 1'b0;
    endcase
  end

  assign cap_dig  = settle_hit && sel_ok;
  assign cap_bad  = settle_hit && !sel_ok && (en_s2_q != 4'b1111);
  assign frame_go = (mask_q == 4'b1111);
  assign to_hit   = !cap_dig && (to_q == TMO_M1);

  always_comb begin
    stab_d = stab_q;
    if (chg)
      stab_d = '0;
    else if (stab_q != SETTLE_MAX)
      stab_d = stab_q + SW'(1);

    to_d = to_q;
    if (cap_dig)
      to_d = '0;
    else if (to_q != TMO_MAX)
      to_d = to_q + TW'(1);

    // A capture landing on the frame cycle already belongs to the next frame.
    mask_d = mask_q;
    if (frame_go || to_hit)
      mask_d = '0;
    if (cap_dig)
      mask_d[sel_idx] = 1'b1;

    stale_d = stale_q;
    if (frame_go)
      stale_d = 1'b0;
    if (to_hit)
      stale_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_s1_q    <= '0;
      en_s2_q    <= '0;
      seg_s1_q   <= '0;
      seg_s2_q   <= '0;
      pat_prev_q <= '0;
      stab_q     <= '0;
      to_q       <= '0;
      mask_q     <= '0;
      stale_q    <= 1'b0;
      value_q    <= '0;
      blank_q    <= '0;
      derr_q     <= '0;
      fv_q       <= 1'b0;
      ferr_q     <= 1'b0;
      oh_err_q   <= 1'b0;
    end else begin
      en_s1_q    <= en_n;
      en_s2_q    <= en_s1_q;
      seg_s1_q   <= segs;
      seg_s2_q   <= seg_s1_q;
      pat_prev_q <= {en_s2_q, seg_s2_q};
      stab_q     <= stab_d;
      to_q       <= to_d;
      mask_q     <= mask_d;
      stale_q    <= stale_d;
      fv_q       <= frame_go;
      oh_err_q   <= cap_bad;
      if (frame_go) begin
        value_q <= {nib_q[3], nib_q[2], nib_q[1], nib_q[0]};
        blank_q <= blk_st_q;
        derr_q  <= derr_st_q;
        ferr_q  <= |derr_st_q;
      end
    end
  end

  // Per-digit store is only read once all four digits were rewritten since the last clear.
  always_ff @(posedge clk) begin
    if (cap_dig) begin
      nib_q[sel_idx]     <= dec[3:0];
      blk_st_q[sel_idx]  <= dec[4];
      derr_st_q[sel_idx] <= dec[5];
    end
  end

`ifdef SEG_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (cap_dig && dec[5] && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      err_cnt_q <= '0;
    else
      err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

  assign value       = value_q;
  assign blank       = blank_q;
  assign digit_err   = derr_q;
  assign frame_valid = fv_q;
  assign frame_err   = ferr_q;
  assign onehot_err  = oh_err_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed and randomized scan sequences checked against a transaction-level display model.
module tb_seg_scan_decoder;
  localparam int SETTLE = 16;
  localparam int TMO    = 200;
  localparam int CAPLAT = SETTLE + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en_n;
  logic [6:0]  segs;
  logic [15:0] value;
  logic [3:0]  blank, digit_err;
  logic        frame_valid, frame_err, onehot_err, stale;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .en_n(en_n), .segs(segs), .value(value), .blank(blank),
    .digit_err(digit_err), .frame_valid(frame_valid), .frame_err(frame_err),
    .onehot_err(onehot_err), .stale(stale), .err_cnt(err_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0]  tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [3:0]  m_nib [4];
  logic [3:0]  m_blk, m_derr, m_mask;
  logic [15:0] m_value;
  logic [3:0]  m_blank_o, m_derr_o;
  logic        m_ferr_o, m_stale;
  logic [10:0] m_prev;
  int          m_errs, m_since;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] ref_dec(input logic [6:0] s);
    if (s == 7'h00) return 6'b01_0000;
    for (int j = 0; j < 16; j++)
      if (tbl[j] == s) return {2'b00, 4'(j)};
    return 6'b10_0000;
  endfunction

  function automatic logic [7:0] exp_err_cnt();
`ifdef SEG_ERR_CNT_EN
    return 8'(m_errs);
`else
    return 8'd0;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    en_n = 4'hF; segs = 7'h00; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_mask = '0; m_errs = 0; m_stale = 1'b0; m_since = 0; m_prev = {4'hF, 7'h00};
    m_value = '0; m_blank_o = '0; m_derr_o = '0; m_ferr_o = 1'b0;
    chk("rst_value", value, 16'h0);
    chk("rst_blank", blank, 4'h0);
    chk("rst_digit_err", digit_err, 4'h0);
    chk("rst_frame_valid", frame_valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_onehot_err", onehot_err, 1'b0);
    chk("rst_stale", stale, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'h0);
  endtask

  task automatic step(input logic [3:0] en, input logic [6:0] sg, input int dwell);
    int fv_n, oh_n, idx;
    logic cap, exp_fv, exp_oh;
    logic [5:0] d;
    fv_n = 0; oh_n = 0;
    @(negedge clk);
    en_n = en; segs = sg;
    for (int i = 0; i < dwell; i++) begin
      @(posedge clk); #1;
      if (frame_valid) fv_n++;
      if (onehot_err) oh_n++;
    end
    cap = (dwell >= SETTLE + 2) && ({en, sg} != m_prev);
    m_prev = {en, sg};
    exp_fv = 1'b0; exp_oh = 1'b0;
    idx = -1;
    for (int k = 0; k < 4; k++)
      if (en == ~(4'b0001 << k)) idx = k;
    if (cap && idx >= 0) begin
      if (m_since + CAPLAT > TMO) begin m_stale = 1'b1; m_mask = '0; end
      d = ref_dec(sg);
      m_nib[idx] = d[3:0]; m_blk[idx] = d[4]; m_derr[idx] = d[5];
      if (d[5] && m_errs < 255) m_errs++;
      m_mask[idx] = 1'b1;
      m_since = dwell - CAPLAT;
      if (m_mask == 4'hF) begin
        exp_fv = 1'b1; m_mask = '0; m_stale = 1'b0;
        m_value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
        m_blank_o = m_blk; m_derr_o = m_derr; m_ferr_o = |m_derr;
      end
    end else begin
      if (cap && en != 4'hF) exp_oh = 1'b1;
      m_since += dwell;
    end
    if (m_since >= TMO) begin m_stale = 1'b1; m_mask = '0; end
    chk("frame_valid_pulses", fv_n, exp_fv);
    chk("onehot_err_pulses", oh_n, exp_oh);
    chk("value", value, m_value);
    chk("blank", blank, m_blank_o);
    chk("digit_err", digit_err, m_derr_o);
    chk("frame_err", frame_err, m_ferr_o);
    chk("err_cnt", err_cnt, exp_err_cnt());
    if (m_since < TMO - 5 || m_since > TMO + 5)
      chk("stale", stale, m_stale);
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                       input logic [6:0] s3, input int dwell);
    step(4'b1110, s0, dwell);
    step(4'b1101, s1, dwell);
    step(4'b1011, s2, dwell);
    step(4'b0111, s3, dwell);
  endtask

  initial begin
    logic [3:0] en;
    logic [6:0] sg;
    int r, nonc;
    rst = 1'b1; en_n = 4'hF; segs = 7'h00;
    repeat (3) @(posedge clk);
    do_reset();

    // Basic scan 1/2/3/4
    scan4(7'h30, 7'h6D, 7'h79, 7'h33, 40);
    chk("t1_value", value, 16'h4321);

    // Undecodable digit 2
    scan4(7'h7E, 7'h30, 7'h01, 7'h33, 40);
    chk("t3_digit_err", digit_err, 4'b0100);
    chk("t3_frame_err", frame_err, 1'b1);

    // Bad enable pattern mid-scan leaves captured digits intact
    step(4'b1110, 7'h5B, 40);
    step(4'b1101, 7'h5F, 40);
    step(4'b0011, 7'h7F, 20);
    step(4'b1011, 7'h70, 40);
    step(4'b0111, 7'h7B, 40);
    chk("t4_value", value, 16'h9765);

    // Blank digit 1
    scan4(7'h77, 7'h00, 7'h4E, 7'h3D, 40);
    chk("t5_blank", blank, 4'b0010);
    chk("t5_frame_err", frame_err, 1'b0);

    // Partial scan, then short dwells until timeout, then a full scan
    step(4'b1110, 7'h4F, 40);
    step(4'b1101, 7'h47, 40);
    for (int i = 0; i < 30; i++)
      step(~(4'b0001 << (i % 4)), tbl[i % 16], 10);
    chk("t2_stale_set", stale, 1'b1);
    scan4(7'h1F, 7'h30, 7'h6D, 7'h79, 40);
    chk("t2_stale_clr", stale, 1'b0);
    chk("t2_value", value, 16'h321B);

    // Randomized scan traffic
    nonc = 0;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 99);
      if (nonc >= 2) r = 0;
      if (r < 75) begin
        en = ~(4'b0001 << $urandom_range(0, 3));
        r = $urandom_range(0, 99);
        if (r < 70) sg = tbl[$urandom_range(0, 15)];
        else if (r < 80) sg = 7'h00;
        else sg = 7'($urandom);
        nonc = 0;
      end else if (r < 90) begin
        en = 4'hF; sg = 7'($urandom); nonc++;
      end else begin
        do en = 4'($urandom);
        while (en == 4'hF || en == 4'hE || en == 4'hD || en == 4'hB || en == 4'h7);
        sg = 7'($urandom); nonc++;
      end
      if ({en, sg} == m_prev) sg = sg ^ 7'h01;
      step(en, sg, $urandom_range(22, 40));
    end

    // Reset after three digits, then a scan of zeros
    step(4'b1110, 7'h30, 40);
    step(4'b1101, 7'h30, 40);
    step(4'b1011, 7'h30, 40);
    do_reset();
    scan4(7'h7E, 7'h7E, 7'h7E, 7'h7E, 40);
    chk("t6_value", value, 16'h0000);
    chk("t6_blank", blank, 4'h0);

    // Error counter saturation
    for (int i = 0; i < 300; i++)
      step(4'b1110, (i % 2 == 0) ? 7'h01 : 7'h02, 22);
`ifdef SEG_ERR_CNT_EN
    chk("t6_err_cnt_sat", err_cnt, 8'd255);
`else
    chk("t6_err_cnt_off", err_cnt, 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
